// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers: sizing helpers
// and the per-stage payload layouts that get packed into pipe_stage_buf.
package pipe_pkg;

  localparam int MAX_PIPE_DEPTH = 8;

  // Bits needed to hold an occupancy of 0..depth.
  function automatic int clog2_cnt(input int depth);
    int w;
    w = 1;
    while ((1 << w) <= depth) w++;
    return w;
  endfunction

  // Bits needed to index 0..depth-1; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_mem_t;

endpackage

// File: rtl/pipe_buf_ptr.sv
// Circular-buffer pointer that wraps from DEPTH-1 back to zero by compare,
// so DEPTH need not be a power of two.
module pipe_buf_ptr
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_d;
  logic [PW-1:0] ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (adv) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline register with DEPTH-entry first-word-fall-through
// storage, synchronous flush and optional pass-through ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 2,
  parameter bit PASS_READY  = 1'b0,
  parameter bit ZERO_BUBBLE = 1'b1,
  localparam int CW         = clog2_cnt(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    count
);

  localparam int PW    = ptr_w(DEPTH);
  localparam int MEM_N = 1 << PW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (DEPTH < 1 || DEPTH > MAX_PIPE_DEPTH) begin : g_bad_depth
    $error("pipe_stage_buf: DEPTH must be within 1..MAX_PIPE_DEPTH");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_stage_buf: WIDTH must be at least 1");
  end

  // Storage rounded up to a power of two so pointer indexing is always in range;
  // entries at DEPTH and above are never addressed.
  logic [WIDTH-1:0] mem_q [MEM_N];
  logic [WIDTH-1:0] mem_d [MEM_N];
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    count_q;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             full;
  logic             push;
  logic             pop;

  assign full      = (count_q == DEPTH_C);
  assign valid_out = (count_q != '0);
  assign ready_out = !full || (PASS_READY && ready_in);
  assign push      = valid_in && ready_out && !flush;
  assign pop       = valid_out && ready_in;
  assign count     = count_q;
  assign data_out  = (ZERO_BUBBLE && !valid_out) ? '0 : mem_q[rd_ptr];

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  pipe_buf_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .adv   (pop),
    .ptr   (rd_ptr)
  );

  pipe_buf_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .adv   (push),
    .ptr   (wr_ptr)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: four configurations checked against a queue model.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] vin, rin, fl, rout, vout;
  logic [3:0][31:0] din, dout;
  logic [3:0][3:0]  cnt;
  int errors = 0;
  int checks = 0;
  int delivered = 0;
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  // u0: DEPTH=2 PR=0, u1: DEPTH=3 PR=0, u2: DEPTH=1 PR=1, u3: DEPTH=1 PR=0
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D = (g == 1) ? 3 : (g >= 2) ? 1 : 2;
    localparam bit P = (g == 2);
    logic [$clog2(D+1)-1:0] c;
    pipe_stage_buf #(.WIDTH(32), .DEPTH(D), .PASS_READY(P), .ZERO_BUBBLE(1'b1)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (fl[g]),
      .valid_in  (vin[g]),
      .ready_out (rout[g]),
      .data_in   (din[g]),
      .valid_out (vout[g]),
      .ready_in  (rin[g]),
      .data_out  (dout[g]),
      .count     (c)
    );
    assign cnt[g] = 4'(c);
  end

  function automatic int dep(input int u);
    return (u == 1) ? 3 : (u >= 2) ? 1 : 2;
  endfunction

  function automatic bit pr(input int u);
    return (u == 2);
  endfunction

  // {valid_out, data_out, count, ready_out} as the queue model predicts it
  function automatic logic [37:0] exp_vec(input int u);
    logic v;
    logic [31:0] d;
    logic r;
    v = (mq.size() != 0);
    d = v ? mq[0] : 32'h0;
    r = (mq.size() < dep(u)) || (pr(u) && rin[u]);
    return {v, d, 4'(mq.size()), r};
  endfunction

  function automatic logic [37:0] act_vec(input int u);
    return {vout[u], dout[u], cnt[u], rout[u]};
  endfunction

  // One clock of stimulus on instance u; model updated at the edge.
  task automatic cyc(input int u, input bit v, input logic [31:0] d, input bit r, input bit f);
    bit push, pop;
    vin[u] = v; din[u] = d; rin[u] = r; fl[u] = f;
    #1;
    pop  = (mq.size() != 0) && r;
    push = v && ((mq.size() < dep(u)) || (pr(u) && r)) && !f;
    @(posedge clk);
    if (f) begin
      mq.delete();
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        delivered++;
      end
      if (push) mq.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; vin = '0; rin = '0; fl = '0; din = '0;
    mq.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (act_vec(0) !== {1'b1 ^ 1'b1, 32'h0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL reset_hold: got %h want %h", act_vec(0), {1'b0, 32'h0, 4'd0, 1'b1});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (act_vec(0) !== {1'b0, 32'h0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL reset_idle: got %h want %h", act_vec(0), {1'b0, 32'h0, 4'd0, 1'b1});
    end
    cyc(0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(0, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (act_vec(0) !== exp_vec(0) || cnt[0] !== 4'd0) begin
      errors++; $display("FAIL empty_no_underflow: got %h want %h", act_vec(0), exp_vec(0));
    end
    cyc(0, 1'b1, 32'h99, 1'b0, 1'b0);
    cyc(0, 1'b1, 32'h9A, 1'b0, 1'b0);
    checks++;
    if (act_vec(0) !== exp_vec(0)) begin
      errors++; $display("FAIL pre_reset_fill: got %h want %h", act_vec(0), exp_vec(0));
    end
    vin[0] = 1'b0;
    #2 reset = 1'b0;
    #1;
    mq.delete();
    checks++;
    if (act_vec(0) !== {1'b0, 32'h0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL reset_async: got %h want %h", act_vec(0), {1'b0, 32'h0, 4'd0, 1'b1});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_streaming();
    logic [31:0] pat [3];
    pat = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b1, pat[i], 1'b1, 1'b0);
      checks++;
      if (act_vec(0) !== {1'b1, pat[i], 4'd1, 1'b1}) begin
        errors++; $display("FAIL stream[%0d]: got %h want %h", i, act_vec(0), {1'b1, pat[i], 4'd1, 1'b1});
      end
    end
    cyc(0, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (act_vec(0) !== exp_vec(0)) begin
      errors++; $display("FAIL stream_drain: got %h want %h", act_vec(0), exp_vec(0));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pat [4];
    pat = '{32'hA, 32'hB, 32'hC, 32'hD};
    for (int i = 0; i < 3; i++) cyc(1, 1'b1, pat[i], 1'b0, 1'b0);
    checks++;
    if (act_vec(1) !== {1'b1, 32'hA, 4'd3, 1'b0}) begin
      errors++; $display("FAIL fill: got %h want %h", act_vec(1), {1'b1, 32'hA, 4'd3, 1'b0});
    end
    cyc(1, 1'b1, pat[3], 1'b0, 1'b0);
    checks++;
    if (act_vec(1) !== {1'b1, 32'hA, 4'd3, 1'b0}) begin
      errors++; $display("FAIL stall_hold: got %h want %h", act_vec(1), {1'b1, 32'hA, 4'd3, 1'b0});
    end
    cyc(1, 1'b1, pat[3], 1'b1, 1'b0);
    checks++;
    if (act_vec(1) !== {1'b1, 32'hB, 4'd2, 1'b1}) begin
      errors++; $display("FAIL release_pop: got %h want %h", act_vec(1), {1'b1, 32'hB, 4'd2, 1'b1});
    end
    cyc(1, 1'b1, pat[3], 1'b1, 1'b0);
    checks++;
    if (act_vec(1) !== {1'b1, 32'hC, 4'd2, 1'b1}) begin
      errors++; $display("FAIL late_accept: got %h want %h", act_vec(1), {1'b1, 32'hC, 4'd2, 1'b1});
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (act_vec(1) !== exp_vec(1)) begin
        errors++; $display("FAIL bp_drain[%0d]: got %h want %h", i, act_vec(1), exp_vec(1));
      end
    end
  endtask

  task automatic test_wrap();
    int idx, cycles;
    bit r, v, acc;
    logic [31:0] cur;
    idx = 0; cycles = 0; delivered = 0;
    cur = $urandom;
    while ((idx < 10 || mq.size() != 0) && cycles < 300) begin
      r = 1'($urandom_range(0, 1));
      v = (idx < 10);
      acc = v && (mq.size() < dep(1));
      cyc(1, v, cur, r, 1'b0);
      cycles++;
      checks++;
      if (act_vec(1) !== exp_vec(1)) begin
        errors++; $display("FAIL wrap cyc %0d: got %h want %h", cycles, act_vec(1), exp_vec(1));
      end
      if (acc) begin
        idx++;
        cur = $urandom;
      end
    end
    checks++;
    if (delivered != 10 || cycles >= 300) begin
      errors++; $display("FAIL wrap_total: delivered %0d want 10 (cycles %0d)", delivered, cycles);
    end
  endtask

  task automatic test_flush();
    cyc(0, 1'b1, 32'h44, 1'b0, 1'b0);
    cyc(0, 1'b1, 32'h45, 1'b0, 1'b0);
    cyc(0, 1'b1, 32'h55, 1'b0, 1'b1);
    checks++;
    if (act_vec(0) !== {1'b0, 32'h0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL flush_full: got %h want %h", act_vec(0), {1'b0, 32'h0, 4'd0, 1'b1});
    end
    cyc(0, 1'b1, 32'h66, 1'b0, 1'b0);
    cyc(0, 1'b1, 32'h55, 1'b1, 1'b1);
    checks++;
    if (act_vec(0) !== {1'b0, 32'h0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL flush_room: got %h want %h", act_vec(0), {1'b0, 32'h0, 4'd0, 1'b1});
    end
    cyc(0, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (act_vec(0) !== exp_vec(0) || dout[0] === 32'h55) begin
      errors++; $display("FAIL flush_after: got %h want %h", act_vec(0), exp_vec(0));
    end
  endtask

  task automatic test_pass_ready();
    cyc(2, 1'b1, 32'h66, 1'b0, 1'b0);
    checks++;
    if (act_vec(2) !== {1'b1, 32'h66, 4'd1, 1'b0}) begin
      errors++; $display("FAIL pr1_full: got %h want %h", act_vec(2), {1'b1, 32'h66, 4'd1, 1'b0});
    end
    vin[2] = 1'b1; din[2] = 32'h77; rin[2] = 1'b1;
    #1;
    checks++;
    if (rout[2] !== 1'b1) begin
      errors++; $display("FAIL pr1_ready: got %b want 1", rout[2]);
    end
    cyc(2, 1'b1, 32'h77, 1'b1, 1'b0);
    checks++;
    if (act_vec(2) !== {1'b1, 32'h77, 4'd1, 1'b1}) begin
      errors++; $display("FAIL pr1_swap: got %h want %h", act_vec(2), {1'b1, 32'h77, 4'd1, 1'b1});
    end
    cyc(2, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(3, 1'b1, 32'h66, 1'b0, 1'b0);
    vin[3] = 1'b1; din[3] = 32'h77; rin[3] = 1'b1;
    #1;
    checks++;
    if (rout[3] !== 1'b0) begin
      errors++; $display("FAIL pr0_ready: got %b want 0", rout[3]);
    end
    cyc(3, 1'b1, 32'h77, 1'b1, 1'b0);
    checks++;
    if (act_vec(3) !== {1'b0, 32'h0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL pr0_pop: got %h want %h", act_vec(3), {1'b0, 32'h0, 4'd0, 1'b1});
    end
    cyc(3, 1'b1, 32'h77, 1'b1, 1'b0);
    checks++;
    if (act_vec(3) !== {1'b1, 32'h77, 4'd1, 1'b0}) begin
      errors++; $display("FAIL pr0_accept: got %h want %h", act_vec(3), {1'b1, 32'h77, 4'd1, 1'b0});
    end
    cyc(3, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (act_vec(3) !== exp_vec(3)) begin
      errors++; $display("FAIL pr0_drain: got %h want %h", act_vec(3), exp_vec(3));
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_flush();
    test_pass_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
